// File: rtl/csi2_nto1_frame_mux.sv
// N-to-1 CSI-2 byte-domain frame multiplexer: forwards whole frames from one
// channel at a time, chosen manually or by round-robin. Switches only at frame ends.
module csi2_nto1_frame_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
    input  logic [NUM_CH-1:0]          ch_valid_i,
    input  logic [NUM_CH-1:0]          ch_fs_i,
    input  logic [NUM_CH-1:0]          ch_fe_i,
    input  logic [NUM_CH-1:0]          ch_en_i,
    input  logic                       mode_i,
    input  logic [CH_W-1:0]            mux_sel_i,
    input  logic [7:0]                 frames_per_ch_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic                       fs_o,
    output logic                       fe_o,
    output logic [CH_W-1:0]            active_ch_o,
    output logic                       switch_pending_o,
    output logic                       err_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic [CH_W-1:0]   tgt;
    logic [7:0]        frame_cnt;
    logic              mode_q;

    logic [DATA_W-1:0] words [NUM_CH];
    logic              cur_v, cur_fs, cur_fe, cur_en;
    logic              sel_in_range, sel_ok;
    logic              mode_chg;
    logic [7:0]        fpc;
    logic              rotate;
    logic [7:0]        cnt_inc;
    logic [CH_W:0]     nxt;

    // Lowest-offset enabled channel after 'from', wrapping; MSB flags a hit.
    function automatic logic [CH_W:0] next_en(input logic [CH_W-1:0] from,
                                              input logic [NUM_CH-1:0] en);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] idx;
        res = '0;
        for (int unsigned i = NUM_CH; i >= 1; i--) begin
            idx = CH_W'((32'(from) + i) % NUM_CH);
            if (en[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            words[k] = ch_data_i[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        cur_v        = ch_valid_i[tgt];
        cur_fs       = ch_fs_i[tgt];
        cur_fe       = ch_fe_i[tgt];
        cur_en       = ch_en_i[tgt];
        sel_in_range = 32'(mux_sel_i) < 32'(NUM_CH);
        sel_ok       = sel_in_range && ch_en_i[mux_sel_i];
        mode_chg     = mode_i != mode_q;
        fpc          = (frames_per_ch_i == 8'd0) ? 8'd1 : frames_per_ch_i;
        rotate       = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, fpc};
        cnt_inc      = (frame_cnt == 8'hFF) ? 8'hFF : frame_cnt + 8'd1;
        nxt          = next_en(tgt, ch_en_i);
    end

    assign active_ch_o = tgt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= IDLE;
            tgt              <= '0;
            frame_cnt        <= '0;
            mode_q           <= mode_i;
            data_o           <= '0;
            valid_o          <= 1'b0;
            fs_o             <= 1'b0;
            fe_o             <= 1'b0;
            switch_pending_o <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            mode_q           <= mode_i;
            valid_o          <= 1'b0;
            fs_o             <= 1'b0;
            fe_o             <= 1'b0;
            err_o            <= 1'b0;
            switch_pending_o <= (state == STREAM) && !mode_i && sel_in_range
                                && (mux_sel_i != tgt);

            case (state)
                IDLE: begin
                    if (cur_v && cur_fs && cur_en) begin
                        state   <= STREAM;
                        data_o  <= words[tgt];
                        valid_o <= 1'b1;
                        fs_o    <= 1'b1;
                    end else if (!mode_chg) begin
                        if (!mode_i && sel_ok && (mux_sel_i != tgt)) begin
                            tgt <= mux_sel_i;
                        end else if (!cur_en && nxt[CH_W]) begin
                            tgt <= nxt[CH_W-1:0];
                        end
                    end
                end

                STREAM: begin
                    if (cur_v) begin
                        data_o  <= words[tgt];
                        valid_o <= 1'b1;
                        fs_o    <= cur_fs;
                        fe_o    <= cur_fe;
                        if (cur_fe) begin
                            state <= IDLE;
                            if (!mode_i) begin
                                frame_cnt <= cnt_inc;
                                if (sel_ok && !mode_chg) tgt <= mux_sel_i;
                            end else if (rotate) begin
                                frame_cnt <= '0;
                                if (nxt[CH_W] && !mode_chg) tgt <= nxt[CH_W-1:0];
                            end else begin
                                frame_cnt <= cnt_inc;
                            end
                        end else if (cur_fs) begin
                            err_o <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // A mode flip restarts the per-channel frame count; later NBA wins.
            if (mode_chg) frame_cnt <= '0;
        end
    end

endmodule
